// File: rtl/picorv32_ddr3_bridge_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ddr3_bridge_pkg
// Brief   : Shared types and constants for the PicoRV32 to DDR3 Avalon bridge.
// Revision: 1.0 - initial release
// ============================================================================
package ddr3_bridge_pkg;

    localparam int AVL_AW   = 21;
    localparam int ADDR_MSB = 22;
    localparam int ADDR_LSB = 2;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_MERGE    = 3'd3,
        ST_WR_ISSUE = 3'd4,
        ST_DONE     = 3'd5
    } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/picorv32_ddr3_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : picorv32_ddr3_bridge_if
// Brief   : CPU native bus plus Avalon-MM command bus seen by the bridge.
// Revision: 1.0 - initial release
// ============================================================================
interface picorv32_ddr3_bridge_if;
    import ddr3_bridge_pkg::*;

    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [AVL_AW-1:0] avl_address;
    logic [31:0]       avl_writedata;
    logic              avl_read;
    logic              avl_write;
    logic [31:0]       avl_readdata;
    logic              avl_readdatavalid;
    logic              init_done;
    logic              timeout_err;

    // Environment side: the CPU issuing requests and the controller answering them.
    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  avl_address, avl_writedata, avl_read, avl_write,
        output avl_readdata, avl_readdatavalid, init_done,
        input  timeout_err
    );

    // Bridge side.
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output avl_address, avl_writedata, avl_read, avl_write,
        input  avl_readdata, avl_readdatavalid, init_done,
        output timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/picorv32_ddr3_bridge_wstrb_merge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : wstrb_merge
// Brief   : Byte-lane merge of store data over a read-back word.
// Revision: 1.0 - initial release
// ============================================================================
module wstrb_merge (
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] merged
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/picorv32_ddr3_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : picorv32_ddr3_bridge
// Brief   : PicoRV32 native bus to word-addressed Avalon-MM, with RMW partial
//           stores and a read timeout that latches a sticky error flag.
// Revision: 1.0 - initial release
// ============================================================================
module picorv32_ddr3_bridge
    import ddr3_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    picorv32_ddr3_bridge_if.slave bus
);

    localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    bridge_state_t     r_state;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_rmw;
    logic [15:0]       r_cnt;
    logic [31:0]       r_readback;
    logic [AVL_AW-1:0] r_avl_address;
    logic [31:0]       r_avl_writedata;
    logic              r_avl_read;
    logic              r_avl_write;
    logic              r_mem_ready;
    logic [31:0]       r_mem_rdata;
    logic              r_timeout_err;
    logic [31:0]       w_merged;

    wstrb_merge u_merge (
        .wdata  (r_wdata),
        .rdata  (r_readback),
        .wstrb  (r_wstrb),
        .merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_wdata         <= '0;
            r_wstrb         <= '0;
            r_rmw           <= 1'b0;
            r_cnt           <= '0;
            r_readback      <= '0;
            r_avl_address   <= '0;
            r_avl_writedata <= '0;
            r_avl_read      <= 1'b0;
            r_avl_write     <= 1'b0;
            r_mem_ready     <= 1'b0;
            r_mem_rdata     <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            // Command and completion strobes are single-cycle pulses.
            r_avl_read  <= 1'b0;
            r_avl_write <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_valid && bus.init_done) begin
                        r_avl_address <= bus.mem_addr[ADDR_MSB:ADDR_LSB];
                        r_wdata       <= bus.mem_wdata;
                        r_wstrb       <= bus.mem_wstrb;
                        if (bus.mem_wstrb == 4'hF) begin
                            r_rmw           <= 1'b0;
                            r_avl_writedata <= bus.mem_wdata;
                            r_avl_write     <= 1'b1;
                            r_state         <= ST_WR_ISSUE;
                        end else begin
                            r_rmw      <= (bus.mem_wstrb != 4'h0);
                            r_avl_read <= 1'b1;
                            r_state    <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // Returned data takes priority over a timeout in the same cycle.
                    if (bus.avl_readdatavalid) begin
                        if (r_rmw) begin
                            r_readback <= bus.avl_readdata;
                            r_state    <= ST_MERGE;
                        end else begin
                            r_mem_rdata <= bus.avl_readdata;
                            r_mem_ready <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_mem_rdata   <= ERR_WORD;
                        r_timeout_err <= 1'b1;
                        r_rmw         <= 1'b0;
                        r_mem_ready   <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_MERGE: begin
                    r_avl_writedata <= w_merged;
                    r_avl_write     <= 1'b1;
                    r_state         <= ST_WR_ISSUE;
                end
                ST_WR_ISSUE: begin
                    r_mem_ready <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.avl_address   = r_avl_address;
    assign bus.avl_writedata = r_avl_writedata;
    assign bus.avl_read      = r_avl_read;
    assign bus.avl_write     = r_avl_write;
    assign bus.mem_ready     = r_mem_ready;
    assign bus.mem_rdata     = r_mem_rdata;
    assign bus.timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/picorv32_ddr3_bridge.md
# picorv32_ddr3_bridge

Translates the PicoRV32 native memory interface into the word-addressed Avalon-MM command interface of the `ddr3_mem` controller wrapper. It sits directly upstream of `ddr3_mem`: one CPU transaction in flight at a time, read-modify-write for partial stores (the Avalon port has no byteenable), and a read timeout with a sticky error flag.

## Interface
- `TIMEOUT_CYCLES`, default 1023: RD_WAIT cycles tolerated before a read is abandoned; legal range 1..65535.
- `ERR_WORD`, default 32'hDEAD_BEEF: value returned on `mem_rdata` when a read times out.
- `clk` in 1: the single clock; all logic is clocked on its rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `mem_valid` in 1: PicoRV32 request valid.
- `mem_addr` in 32: byte address. Bits [22:2] are used; all other bits are ignored.
- `mem_wdata` in 32: store data.
- `mem_wstrb` in 4: byte strobes. 0 means read.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data, valid while `mem_ready` is high.
- `avl_address` out 21: word address, equal to `mem_addr[22:2]`.
- `avl_writedata` out 32: write data to the controller.
- `avl_read` out 1: one-cycle read command.
- `avl_write` out 1: one-cycle write command.
- `avl_readdata` in 32: read return data.
- `avl_readdatavalid` in 1: read return strobe.
- `init_done` in 1: controller calibration complete.
- `timeout_err` out 1: sticky. Set on any read timeout and cleared only by reset.

## Operation
- **States:** IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, DONE. The state encoding is 3 bits.
- **IDLE:** accepts only when `mem_valid && init_done`. It latches the address, wdata and wstrb.
  - wstrb == 0 → RD_ISSUE.
  - wstrb == 4'hF → WR_ISSUE.
  - Any other wstrb → RD_ISSUE, with the RMW flag set.
- **While `init_done` is low:** requests stay pending, no Avalon command is issued, and `mem_ready` stays 0.
- **RD_ISSUE:** `avl_read` = 1 for exactly one cycle, then → RD_WAIT. The timeout counter is cleared.
- **RD_WAIT:**
  - On `avl_readdatavalid`, capture `avl_readdata`. If the RMW flag is set → MERGE, otherwise → DONE with `mem_rdata` = the captured data.
  - If the counter reaches `TIMEOUT_CYCLES` first: `mem_rdata` = `ERR_WORD`, `timeout_err` is set, the RMW flag is dropped (no write is issued), and the FSM → DONE.
- **MERGE:** for each byte i, merged[i] = wstrb[i] ? wdata[i] : readback[i]. The result is registered, then → WR_ISSUE.
- **WR_ISSUE:** `avl_write` = 1 for one cycle, with `avl_writedata` = latched wdata or the merged word. Then → DONE. Writes are fire-and-forget; the controller accepts them without backpressure.
- **DONE:** `mem_ready` = 1 for one cycle, then → IDLE.
- **`mem_rdata` after a write:** holds the last read value and is not meaningful.
- **Stray strobes:** `avl_readdatavalid` outside RD_WAIT is ignored. This includes a late return after a timeout.
- **Reset:** reset mid-transaction returns the FSM to IDLE. Any in-flight Avalon read return is then ignored.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, and `timeout_err` is 0.
- **Avalon outputs:** `avl_address` / `avl_writedata` are registered and are stable for the whole cycle in which `avl_read` / `avl_write` is high.
- **Full write:** request accepted at edge 0, `avl_write` high in cycle 1, `mem_ready` high in cycle 2.
- **Read:** request accepted at edge 0, `avl_read` high in cycle 1. With `avl_readdatavalid` in cycle k, `mem_ready` is high in cycle k+1 (one registered stage).
- **Partial write:** `avl_readdatavalid` in cycle k → MERGE in cycle k+1 → `avl_write` in cycle k+2 → `mem_ready` in cycle k+3.
- **Timeout:** the counter increments every RD_WAIT cycle without a return. The abort happens after exactly `TIMEOUT_CYCLES` RD_WAIT cycles, and `mem_ready` follows in the next cycle.
- **Simultaneous events:** `avl_readdatavalid` in the same cycle the counter hits its limit counts as success; data wins over timeout.
- **Back-to-back requests:** the earliest next acceptance is the cycle after DONE. PicoRV32 drops `mem_valid` one cycle after `mem_ready`, so the same request is never re-accepted.

## Structure
- **Shared package `ddr3_bridge_pkg`:**
  - state enum;
  - `AVL_AW` = 21;
  - the default `ERR_WORD`;
  - the address-slice constants (bits 22:2).
- **Sub-module `wstrb_merge`:** combinational byte-lane merge with inputs wdata, rdata, wstrb and output merged. It is reused by the future cache fill path.

## Test plan
- **Full write then read:** write addr 0x0000_0010, data 0x1234_5678, wstrb F.
  - Expect `avl_write` with `avl_address` = 4, then `mem_ready` in cycle 2.
  - Then read the same address with readdatavalid latency 5. Expect `mem_rdata` = 0x1234_5678 with `mem_ready` in cycle 7.
- **Partial store (RMW):** memory word = 0xAABB_CCDD; wdata 0x1122_3344, wstrb 0101.
  - Expect one `avl_read`, then `avl_write` with `avl_writedata` = 0xAA22_CC44, then `mem_ready`.
- **Init gating:** hold `init_done` = 0 for 20 cycles with `mem_valid` high.
  - Expect no `avl_read` / `avl_write` and no `mem_ready` during those cycles.
  - Expect the normal sequence after `init_done` rises.
- **Timeout:** use `TIMEOUT_CYCLES` = 8 and never assert readdatavalid.
  - Expect `mem_rdata` = 0xDEAD_BEEF, `timeout_err` = 1, and a one-cycle `mem_ready`.
  - Then inject a late readdatavalid and check that it is ignored.
  - For a timed-out partial store, expect no `avl_write`.
- **Reset mid-operation:** assert `resetn` = 0 in RD_WAIT.
  - Expect all outputs 0 the next cycle.
  - A following readdatavalid is ignored, and a new read then completes correctly.
- **Address mapping:** `mem_addr` = 0xFF80_0004. Expect `avl_address` = 21'h00_0001.
